// File: rtl/yblock_cfg_pkg.sv
// Shared types and defaults for the yellow-cell block configuration loader.
// State encoding, parameter defaults and the configuration word width.
package yblock_cfg_pkg;

  localparam int BLOCKWIDTH_D  = 8;
  localparam int BLOCKHEIGHT_D = 8;
  localparam int PHASE_D       = 2;
  localparam int RSTCYC_D      = 4;
  localparam int CBITS         = 4 * BLOCKWIDTH_D;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT,
    SETUP,
    PULSE,
    HOLD
  } state_t;

endpackage

// File: rtl/yblock_cfg_loader_strobe.sv
// confclk strobe generator: SETUP, PULSE and HOLD phases of PHASE cycles.
// A go pulse starts one strobe; phase_last marks the last cycle of a phase.
module cfg_strobe_gen
  import yblock_cfg_pkg::*;
#(
  parameter int PHASE = PHASE_D
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  output logic confclk,
  output logic phase_last
);

  localparam int PW = (PHASE > 1) ? $clog2(PHASE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PHASE - 1);

  logic          active;
  logic [1:0]    ph;
  logic [PW-1:0] cnt;

  // phase counter and phase index; reset drops the strobe at once
  always_ff @(posedge clk) begin
    if (!reset) begin
      active <= 1'b0;
      ph     <= 2'd0;
      cnt    <= '0;
    end else if (go) begin
      active <= 1'b1;
      ph     <= 2'd0;
      cnt    <= '0;
    end else if (active) begin
      if (cnt == PLAST) begin
        cnt <= '0;
        if (ph == 2'd2) active <= 1'b0;
        else            ph     <= ph + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign confclk    = active && (ph == 2'd1);
  assign phase_last = active && (cnt == PLAST);

endmodule

// File: rtl/yblock_cfg_loader.sv
// Configuration chain writer for a yellow-cell block (rows via valid/ready).
// Optional readback of the shifted-out rows: YBLOCK_CFG_READBACK_EN.
module yblock_cfg_loader
  import yblock_cfg_pkg::*;
#(
  parameter int BLOCKWIDTH  = BLOCKWIDTH_D,
  parameter int BLOCKHEIGHT = BLOCKHEIGHT_D,
  parameter int PHASE       = PHASE_D,
  parameter int RSTCYC      = RSTCYC_D
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [4*BLOCKWIDTH-1:0] cfg_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic                    blk_reset,
  output logic                    blk_confclk,
  output logic [4*BLOCKWIDTH-1:0] blk_cbitin,
  input  logic [4*BLOCKWIDTH-1:0] blk_cbitout,
  output logic [4*BLOCKWIDTH-1:0] rd_data,
  output logic                    rd_valid
);

  localparam int HW = $clog2(BLOCKHEIGHT + 1);
  localparam int RW = $clog2(RSTCYC + 1);
  localparam logic [HW-1:0] RLAST = HW'(BLOCKHEIGHT - 1);
  localparam logic [RW-1:0] CLAST = RW'(RSTCYC - 1);

  state_t        state;
  state_t        next;
  logic [HW-1:0] row;
  logic [RW-1:0] rcnt;
  logic          go;
  logic          phase_last;

  cfg_strobe_gen #(
    .PHASE (PHASE)
  ) u_strobe (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .confclk    (blk_confclk),
    .phase_last (phase_last)
  );

  // state register plus row, clear counter and block edge registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      row        <= '0;
      rcnt       <= '0;
      blk_reset  <= 1'b1;
      blk_cbitin <= '0;
    end else begin
      state <= next;
      unique case (state)
        IDLE: begin
          if (start) begin
            blk_reset <= 1'b1;
            rcnt      <= '0;
          end
        end
        CLEAR: begin
          rcnt <= rcnt + 1'b1;
          if (rcnt == CLAST) begin
            blk_reset <= 1'b0;
            row       <= '0;
          end
        end
        WAIT: begin
          if (cfg_valid) blk_cbitin <= cfg_data;
        end
        HOLD: begin
          if (phase_last) row <= row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // next state, handshake and status outputs
  always_comb begin
    next      = state;
    go        = 1'b0;
    cfg_ready = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) next = CLEAR;
      end
      CLEAR: begin
        if (rcnt == CLAST) next = WAIT;
      end
      WAIT: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          go   = 1'b1;
          next = SETUP;
        end
      end
      SETUP: begin
        if (phase_last) next = PULSE;
      end
      PULSE: begin
        if (phase_last) next = HOLD;
      end
      HOLD: begin
        if (phase_last) begin
          if (row == RLAST) begin
            done = 1'b1;
            next = IDLE;
          end else begin
            next = WAIT;
          end
        end
      end
      default: next = IDLE;
    endcase
  end

`ifdef YBLOCK_CFG_READBACK_EN
  // capture the row shifted out of the block as each strobe ends
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (state == HOLD) && phase_last;
      if ((state == HOLD) && phase_last) rd_data <= blk_cbitout;
    end
  end
`else
  logic unused_cbitout;
  assign unused_cbitout = ^blk_cbitout;
  assign rd_data  = '0;
  assign rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_yblock_cfg_loader.sv
// Self-checking bench for yblock_cfg_loader with a behavioural block model.
// Readback checks are active when YBLOCK_CFG_READBACK_EN is defined.
module tb_yblock_cfg_loader;
  import yblock_cfg_pkg::*;

  localparam int P  = PHASE_D;
  localparam int R  = RSTCYC_D;
  localparam int BH = BLOCKHEIGHT_D;
  localparam int CB = CBITS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, cfg_ready;
  logic [CB-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          blk_reset, blk_confclk;
  logic [CB-1:0] blk_cbitin, blk_cbitout, rd_data;
  logic          rd_valid;

  yblock_cfg_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .blk_reset   (blk_reset),
    .blk_confclk (blk_confclk),
    .blk_cbitin  (blk_cbitin),
    .blk_cbitout (blk_cbitout),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [CB-1:0] act,
                     input logic [CB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s cycle %0d: got %0h expected %0h",
                 nm, cyc, act, exp);
    end
  endtask

  // block: shift chain clocked by confclk, cbitout shows the row shifted out
  logic [CB-1:0] brow [BH];
  logic [CB-1:0] bout = '0;
  assign blk_cbitout = bout;
  always @(posedge blk_confclk) begin
    bout <= brow[BH-1];
    for (int i = BH - 1; i > 0; i--) brow[i] <= brow[i-1];
    brow[0] <= blk_cbitin;
  end

  // stimulus source
  logic [CB-1:0] words [16];
  int  acc = 0;
  int  acc0 = 0;
  bit  feed = 0;
  bit  stall = 0;
  logic rdy_q = 1'b0;

  // model state: timestamps of load start and of current row acceptance
  bit            m_load = 0;
  int            m_t0 = 0;
  int            m_rt = -1;
  int            m_rows = 0;
  logic          m_rst = 1'b1;
  logic [CB-1:0] m_cbit = '0;
  logic [CB-1:0] m_arr [BH];
  logic [CB-1:0] m_out = '0;
  logic          m_rdv = 1'b0;
  logic [CB-1:0] m_rdd = '0;

  // observation counters
  int rises = 0, run = 0, bad_runs = 0, done_cnt = 0, done_cyc = 0;
  logic cc_prev = 1'b0;
  logic [CB-1:0] rdq [$];

  task automatic model_step();
    int k, d;
    bit o_load, o_ready, o_last;
    logic e_ready, e_clk, e_done, e_rdv;
    logic [CB-1:0] e_rdd;
    k = cyc;
    o_load  = m_load;
    o_ready = m_load && m_rt < 0 && (k - 1 - m_t0) >= R;
    o_last  = m_load && m_rt >= 0 && (k - 1 - m_rt) == 3 * P - 1;
    if (!reset) begin
      m_load = 0; m_rst = 1'b1; m_cbit = '0; m_rt = -1;
      m_rows = 0; m_rdv = 1'b0; m_rdd = '0;
    end else begin
      m_rdv = 1'b0;
      if (o_last) begin
        m_rdv = 1'b1; m_rdd = m_out; m_rows++; m_rt = -1;
        if (m_rows == BH) m_load = 0;
      end
      if (!o_load && start) begin
        m_load = 1; m_t0 = k; m_rst = 1'b1; m_rows = 0; m_rt = -1;
      end
      if (o_ready && cfg_valid) begin
        m_rt = k; m_cbit = cfg_data;
      end
      if (m_load && k - m_t0 == R) m_rst = 1'b0;
      if (m_load && m_rt >= 0 && k - m_rt == P) begin
        m_out = m_arr[BH-1];
        for (int i = BH - 1; i > 0; i--) m_arr[i] = m_arr[i-1];
        m_arr[0] = m_cbit;
      end
    end
    d = k - m_rt;
    e_ready = m_load && m_rt < 0 && (k - m_t0) >= R;
    e_clk   = m_load && m_rt >= 0 && d >= P && d < 2 * P;
    e_done  = m_load && m_rt >= 0 && d == 3 * P - 1 && m_rows == BH - 1;
`ifdef YBLOCK_CFG_READBACK_EN
    e_rdv = m_rdv; e_rdd = m_rdd;
`else
    e_rdv = 1'b0; e_rdd = '0;
`endif
    chk("busy", busy, m_load);
    chk("blk_reset", blk_reset, m_rst);
    chk("cfg_ready", cfg_ready, e_ready);
    chk("confclk", blk_confclk, e_clk);
    chk("done", done, e_done);
    chk("cbitin", blk_cbitin, m_cbit);
    chk("rd_valid", rd_valid, e_rdv);
    chk("rd_data", rd_data, e_rdd);
    if (reset && cfg_valid && rdy_q) acc++;
    rdy_q = cfg_ready;
    if (blk_confclk && !cc_prev) rises++;
    if (blk_confclk) run++;
    else if (run > 0) begin
      if (run != P) bad_runs++;
      run = 0;
    end
    cc_prev = blk_confclk;
    if (done) begin done_cnt++; done_cyc = k; end
    if (rd_valid) rdq.push_back(rd_data);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    model_step();
  end

  task automatic tick();
    @(negedge clk);
    cfg_data  = words[(acc - acc0) % 16];
    cfg_valid = feed && !stall;
  endtask

  task automatic run_load(input logic [CB-1:0] base, input int rp,
                          input int stall_row, input int exp_lat);
    int s, scnt;
    bit stalled;
    scnt = 0; stalled = 0;
    for (int i = 0; i < 16; i++) words[i] = base + CB'(i);
    acc0 = acc; feed = 1; stall = 0;
    rises = 0; bad_runs = 0; done_cnt = 0;
    tick();
    start = 1'b1; s = cyc;
    for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
      tick();
      start = (rp > 0 && n == rp);
      if (stall_row >= 0 && !stalled && acc - acc0 == stall_row + 1) begin
        stalled = 1; scnt = 16;
      end
      stall = (scnt > 0);
      if (scnt > 0) scnt--;
      cfg_valid = feed && !stall;
    end
    start = 1'b0;
    chk("done_seen", done_cnt, 1);
    chk("latency", done_cyc - s, exp_lat);
    feed = 0;
    for (int n = 0; n < 20; n++) tick();
    chk("done_once", done_cnt, 1);
    chk("strobes", rises, BH);
    chk("bad_runs", bad_runs, 0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_blk_reset", blk_reset, 1'b0);
    for (int r = 0; r < BH; r++) begin
      chk("block_row", brow[r], base + CB'(BH - 1 - r));
      chk("model_row", m_arr[r], brow[r]);
    end
  endtask

  initial begin
    for (int i = 0; i < BH; i++) begin
      brow[i] = '0;
      m_arr[i] = '0;
    end
    for (int i = 0; i < 16; i++) words[i] = '0;

    // reset release with no start
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    chk("t1_blk_reset", blk_reset, 1'b1);
    chk("t1_confclk", blk_confclk, 1'b0);
    chk("t1_ready", cfg_ready, 1'b0);
    chk("t1_busy", busy, 1'b0);

    // start and reset together: reset wins
    start = 1'b1; reset = 1'b0;
    tick();
    start = 1'b0; reset = 1'b1;
    tick();
    chk("t1_start_rst", busy, 1'b0);

    // plain load of words 0..7
    run_load('0, 0, -1, R + BH * (1 + 3 * P));
    chk("t2_row0", brow[0], CB'(7));
    chk("t2_row7", brow[7], CB'(0));

    // 10-cycle stall after row 3
    run_load(CB'(32'h10), 0, 3, R + BH * (1 + 3 * P) + 10);

    // reset during the PULSE of row 5, then a clean reload
    for (int i = 0; i < 16; i++) words[i] = CB'(32'h100 + i);
    acc0 = acc; feed = 1;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    for (int n = 0; n < 500 && acc - acc0 < 6; n++) tick();
    chk("t4_row5_taken", acc - acc0, 6);
    repeat (P) tick();
    chk("t4_in_pulse", blk_confclk, 1'b1);
    reset = 1'b0; feed = 0;
    tick();
    chk("t4_confclk", blk_confclk, 1'b0);
    chk("t4_blk_reset", blk_reset, 1'b1);
    chk("t4_busy", busy, 1'b0);
    reset = 1'b1;
    repeat (3) tick();
    run_load(CB'(32'h200), 0, -1, R + BH * (1 + 3 * P));

    // start re-pulsed while busy
    run_load(CB'(32'h300), 25, -1, R + BH * (1 + 3 * P));

`ifdef YBLOCK_CFG_READBACK_EN
    // readback: load B reads back A bottom row first
    run_load(CB'(32'hA5A50000), 0, -1, R + BH * (1 + 3 * P));
    rdq.delete();
    run_load(CB'(32'h5A5A0000), 0, -1, R + BH * (1 + 3 * P));
    chk("t6_rd_count", rdq.size(), BH);
    for (int i = 0; i < BH && i < rdq.size(); i++)
      chk("t6_rd_row", rdq[i], CB'(32'hA5A50000 + i));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/yblock_cfg_loader.md
Name: yblock_cfg_loader

Overview:
- Clocked writer for the configuration chain of a yellow-cell block: takes row-wide configuration words from a synchronous host over a valid/ready stream and drives the block's reset, confclk and cbitin edge.
- Shifts exactly BLOCKHEIGHT rows per load and generates confclk strobes with guaranteed setup and hold around each edge.
- Sits between the user-area bus logic and a block's top configuration edge.

Parameters:
- BLOCKWIDTH, 8, cells per row; configuration word width is 4*BLOCKWIDTH.
- BLOCKHEIGHT, 8, rows per load, which is the number of confclk strobes.
- PHASE, 2, clk cycles per strobe phase (setup, high, hold); valid range 1..15.
- RSTCYC, 4, clk cycles blk_reset is held in the CLEAR state; valid range 1..255.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last strobe's HOLD phase ends.
- cfg_data  in  4*BLOCKWIDTH  one row of configuration bits.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  loader accepts cfg_data this cycle.
- blk_reset  out  1  drives the block reset; active-high.
- blk_confclk  out  1  drives the block confclk.
- blk_cbitin  out  4*BLOCKWIDTH  drives the block cbitin; registered.
- blk_cbitout  in  4*BLOCKWIDTH  the block's cbitout; used only when the optional feature is compiled in.
- rd_data  out  4*BLOCKWIDTH  readback row.
- rd_valid  out  1  readback strobe.

Behaviour:
- Reset values (reset low at a clk edge):
  - State = IDLE.
  - blk_reset = 1, so the block is frozen while the loader is in reset.
  - blk_confclk, blk_cbitin, cfg_ready, busy, done, rd_data and rd_valid = 0.
  - Row and phase counters = 0.
- Reset mid-operation aborts immediately to these values. No partial strobe is finished, and blk_confclk drops in the same cycle.
- IDLE:
  - blk_reset keeps its last value: 1 after reset, 0 after a completed load.
  - start = 1 -> CLEAR, phase counter cleared.
- CLEAR:
  - blk_reset = 1 for RSTCYC cycles, then -> WAIT with blk_reset = 0 and the row counter cleared.
- WAIT:
  - cfg_ready = 1, blk_confclk = 0.
  - On cfg_valid & cfg_ready, cfg_data is registered into blk_cbitin -> SETUP.
  - cfg_valid low stalls indefinitely.
- SETUP: blk_confclk = 0 for PHASE cycles -> PULSE.
- PULSE: blk_confclk = 1 for PHASE cycles -> HOLD.
- HOLD:
  - blk_confclk = 0 for PHASE cycles.
  - The row counter increments on exit.
  - If the count reaches BLOCKHEIGHT: done = 1 for one cycle -> IDLE. Otherwise -> WAIT.
- blk_cbitin changes only on a WAIT acceptance. It is stable from SETUP entry through HOLD exit.
- cfg_ready is 0 in every state except WAIT.
- A start pulse while busy is ignored.
- When start and reset arrive in the same cycle, reset wins.
- Row order: the first accepted word ends in the bottom row (BLOCKHEIGHT-1); the last accepted word ends in row 0.
- Per-row latency: 1 accept cycle + 3*PHASE cycles. A full load with cfg_valid held high takes RSTCYC + BLOCKHEIGHT*(1+3*PHASE) cycles from the cycle after start.
- Counter widths are sized by $clog2, with the row counter able to hold BLOCKHEIGHT. No wrap occurs because the counters are cleared on state entry.

Optional Feature:
- Macro: YBLOCK_CFG_READBACK_EN.
- When defined:
  - On the last cycle of each HOLD, rd_data is captured from blk_cbitout and rd_valid pulses for one cycle.
  - Across one load, the loader emits the previous configuration, bottom row first.
  - There is no back-pressure; a host that needs the data must take it the same cycle.
- When undefined:
  - rd_data and rd_valid are tied to 0.
  - blk_cbitout is unused and produces no logic.

Decomposition:
- Shared package (yblock_cfg_pkg):
  - State encoding enum: IDLE, CLEAR, WAIT, SETUP, PULSE, HOLD.
  - Parameter defaults.
  - Localparam CBITS = 4*BLOCKWIDTH.
- One sub-module, cfg_strobe_gen:
  - Owns the phase counter and the SETUP/PULSE/HOLD sequencing.
  - Input go; outputs confclk and phase_last.
  - The top FSM keeps the row counting and the handshake.

Test Plan:
1. Reset release with no start -> blk_reset = 1, blk_confclk = 0, cfg_ready = 0, busy = 0 indefinitely.
2. PHASE=2, RSTCYC=4, BLOCKHEIGHT=8, start pulse, cfg_valid held high with words 0..7:
   - Exactly 8 confclk pulses, each high for 2 cycles.
   - blk_cbitin is stable from 2 cycles before each rise to 2 cycles after each fall.
   - done arrives 4 + 8*7 = 60 cycles after start.
   - A block model ends with row 0 = 7 and row 7 = 0.
3. cfg_valid dropped for 10 cycles after row 3 -> loader holds WAIT with confclk = 0; the total load is 10 cycles longer and the contents are unchanged.
4. Reset asserted during the PULSE of row 5 -> confclk is 0 the next cycle, blk_reset = 1, state IDLE. A restarted load then completes correctly.
5. start re-pulsed while busy -> ignored: still exactly 8 strobes and one done.
6. With YBLOCK_CFG_READBACK_EN, two back-to-back loads A then B -> the second load yields 8 rd_valid pulses carrying the A rows in bottom-first order (A0..A7).
